// File: rtl/ram_arb_pkg.sv
// Shared constants for the two-port RAM arbiter: FSM state encoding and reset
// value of the last-served pointer.
package ram_arb_pkg;

  // state | meaning
  // RR    | round-robin between both requesters
  // LOCK0 | requester 0 holds the RAM port
  // LOCK1 | requester 1 holds the RAM port
  localparam logic [1:0] ST_RR    = 2'd0;
  localparam logic [1:0] ST_LOCK0 = 2'd1;
  localparam logic [1:0] ST_LOCK1 = 2'd2;

  // last = 1 means requester 1 was served last, so requester 0 wins next
  localparam logic LAST_RST = 1'b1;

endpackage

// File: rtl/ram_arb_rr_pick2.sv
// Two-way round-robin pick: one-hot grant, favouring the requester that was
// not served last when both ask.
module rr_pick2 (
  input  logic       req0,
  input  logic       req1,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (req0 && req1) begin
      gnt = last ? 2'b01 : 2'b10;
    end else if (req0) begin
      gnt = 2'b01;
    end else if (req1) begin
      gnt = 2'b10;
    end
  end

endmodule

// File: rtl/ram_arb.sv
// Arbiter sharing one external single-port RAM between two requesters, with
// round-robin fairness, optional grant locking and a lock-length limit.
module ram_arb
  import ram_arb_pkg::*;
#(
  parameter int AWID    = 8,
  parameter int DWID    = 16,
  parameter int MAXLOCK = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_req0,
  input  logic            i_req1,
  input  logic            i_we0,
  input  logic            i_we1,
  input  logic [AWID-1:0] i_addr0,
  input  logic [AWID-1:0] i_addr1,
  input  logic [DWID-1:0] i_data0,
  input  logic [DWID-1:0] i_data1,
  input  logic            i_lock0,
  input  logic            i_lock1,
  output logic            o_gnt0,
  output logic            o_gnt1,
  output logic            o_rvalid0,
  output logic            o_rvalid1,
  output logic [DWID-1:0] o_rdata,
  output logic            o_ram_we,
  output logic [AWID-1:0] o_ram_addr,
  output logic [DWID-1:0] o_ram_data,
  input  logic [DWID-1:0] i_ram_data
);

  localparam int CW = $clog2(MAXLOCK + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAXLOCK);

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic          last;
  logic          last_nxt;
  logic [CW-1:0] lock_cnt;
  logic [CW-1:0] cnt_nxt;
  logic [CW-1:0] cnt_inc;
  logic [1:0]    rr_gnt;
  logic          gnt0;
  logic          gnt1;
  logic          acc_lock;
  logic          other_req;
  logic          rv0_q;
  logic          rv1_q;

  rr_pick2 u_pick (
    .req0 (i_req0),
    .req1 (i_req1),
    .last (last),
    .gnt  (rr_gnt)
  );

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      case (state)
        ST_LOCK0: gnt0 = i_req0;
        ST_LOCK1: gnt1 = i_req1;
        default: begin
          gnt0 = rr_gnt[0];
          gnt1 = rr_gnt[1];
        end
      endcase
    end
  end

  assign o_gnt0 = gnt0;
  assign o_gnt1 = gnt1;

  // The counter is zero in RR, so the first locked grant counts as one.
  assign cnt_inc = (lock_cnt == CNT_MAX) ? CNT_MAX : lock_cnt + CW'(1);

  always_comb begin
    state_nxt = ST_RR;
    last_nxt  = last;
    cnt_nxt   = '0;
    acc_lock  = gnt0 ? i_lock0 : i_lock1;
    other_req = gnt0 ? i_req1 : i_req0;
    if (gnt0 || gnt1) begin
      last_nxt = gnt1;
      if ((cnt_inc == CNT_MAX) && other_req) begin
        state_nxt = ST_RR;
        cnt_nxt   = '0;
      end else if (acc_lock) begin
        state_nxt = gnt0 ? ST_LOCK0 : ST_LOCK1;
        cnt_nxt   = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_RR;
      last     <= LAST_RST;
      lock_cnt <= '0;
      rv0_q    <= 1'b0;
      rv1_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      last     <= last_nxt;
      lock_cnt <= cnt_nxt;
      rv0_q    <= gnt0 & ~i_we0;
      rv1_q    <= gnt1 & ~i_we1;
    end
  end

  // A read issued just before reset must not surface during the reset cycle.
  assign o_rvalid0 = rv0_q & ~rst;
  assign o_rvalid1 = rv1_q & ~rst;
  assign o_rdata   = i_ram_data;

  assign o_ram_we   = (gnt0 & i_we0) | (gnt1 & i_we1);
  assign o_ram_addr = gnt1 ? i_addr1 : i_addr0;
  assign o_ram_data = gnt1 ? i_data1 : i_data0;

endmodule

// File: tb/tb_ram_arb.sv
// Bench for ram_arb: directed vector table followed by random traffic, both
// checked against a transaction-level reference model and a RAM model.
module tb_ram_arb;

  localparam int AWID    = 8;
  localparam int DWID    = 16;
  localparam int MAXLOCK = 4;

  typedef struct {
    bit             rst;
    bit             req0, req1, we0, we1, lk0, lk1;
    logic [AWID-1:0] a0, a1;
    logic [DWID-1:0] d0, d1;
    bit             eg0, eg1, erv0, erv1;
    logic [DWID-1:0] erd;
  } vec_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            req0 = 0, req1 = 0, we0 = 0, we1 = 0, lk0 = 0, lk1 = 0;
  logic [AWID-1:0] a0 = '0, a1 = '0;
  logic [DWID-1:0] d0 = '0, d1 = '0;
  logic            gnt0, gnt1, rvalid0, rvalid1, ram_we;
  logic [DWID-1:0] rdata, ram_wdata, ram_q;
  logic [AWID-1:0] ram_addr;

  logic [DWID-1:0] mem     [0:(1<<AWID)-1];
  logic [DWID-1:0] ref_mem [0:(1<<AWID)-1];

  int n_chk = 0;
  int n_err = 0;

  // reference model: owner -1 means free round-robin
  int              m_owner = -1;
  int              m_cnt   = 0;
  int              m_last  = 1;
  bit              m_pv0 = 0, m_pv1 = 0;
  logic [DWID-1:0] m_pdata = '0;

  vec_t vecs[$];

  always #5 clk = ~clk;

  ram_arb #(.AWID(AWID), .DWID(DWID), .MAXLOCK(MAXLOCK)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_req0     (req0),
    .i_req1     (req1),
    .i_we0      (we0),
    .i_we1      (we1),
    .i_addr0    (a0),
    .i_addr1    (a1),
    .i_data0    (d0),
    .i_data1    (d1),
    .i_lock0    (lk0),
    .i_lock1    (lk1),
    .o_gnt0     (gnt0),
    .o_gnt1     (gnt1),
    .o_rvalid0  (rvalid0),
    .o_rvalid1  (rvalid1),
    .o_rdata    (rdata),
    .o_ram_we   (ram_we),
    .o_ram_addr (ram_addr),
    .o_ram_data (ram_wdata),
    .i_ram_data (ram_q)
  );

  // external RAM with registered read data
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_q <= mem[ram_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(bit r, bit q0, bit q1, bit w0, bit w1, bit l0, bit l1,
                              logic [AWID-1:0] x0, logic [AWID-1:0] x1,
                              logic [DWID-1:0] y0, logic [DWID-1:0] y1,
                              bit g0, bit g1, bit v0, bit v1, logic [DWID-1:0] rd);
    vec_t v;
    v.rst = r; v.req0 = q0; v.req1 = q1; v.we0 = w0; v.we1 = w1; v.lk0 = l0; v.lk1 = l1;
    v.a0 = x0; v.a1 = x1; v.d0 = y0; v.d1 = y1;
    v.eg0 = g0; v.eg1 = g1; v.erv0 = v0; v.erv1 = v1; v.erd = rd;
    return v;
  endfunction

  // Applies one cycle of stimulus, checks outputs mid-cycle, advances the model.
  task automatic run_cycle(input vec_t v, input bit use_tab);
    bit g0, g1, ev0, ev1, other, lk;
    int k;
    rst = v.rst; req0 = v.req0; req1 = v.req1; we0 = v.we0; we1 = v.we1;
    lk0 = v.lk0; lk1 = v.lk1; a0 = v.a0; a1 = v.a1; d0 = v.d0; d1 = v.d1;
    #4;
    g0 = 0; g1 = 0;
    if (v.rst) begin
      g0 = 0; g1 = 0;
    end else if (m_owner == 0) begin
      g0 = v.req0;
    end else if (m_owner == 1) begin
      g1 = v.req1;
    end else if (v.req0 && v.req1) begin
      if (m_last == 0) g1 = 1; else g0 = 1;
    end else begin
      g0 = v.req0; g1 = v.req1;
    end
    ev0 = m_pv0 && !v.rst;
    ev1 = m_pv1 && !v.rst;

    chk("gnt0", 32'(gnt0), 32'(g0));
    chk("gnt1", 32'(gnt1), 32'(g1));
    chk("ram_we", 32'(ram_we), 32'((g0 && v.we0) || (g1 && v.we1)));
    if (g0 || g1) begin
      chk("ram_addr", 32'(ram_addr), 32'(g1 ? v.a1 : v.a0));
      if (g1 ? v.we1 : v.we0) chk("ram_data", 32'(ram_wdata), 32'(g1 ? v.d1 : v.d0));
    end
    chk("rvalid0", 32'(rvalid0), 32'(ev0));
    chk("rvalid1", 32'(rvalid1), 32'(ev1));
    if (ev0 || ev1) chk("rdata", 32'(rdata), 32'(m_pdata));
    if (use_tab) begin
      chk("tab_gnt", 32'({gnt1, gnt0}), 32'({v.eg1, v.eg0}));
      chk("tab_rvalid", 32'({rvalid1, rvalid0}), 32'({v.erv1, v.erv0}));
      if (v.erv0 || v.erv1) chk("tab_rdata", 32'(rdata), 32'(v.erd));
    end

    if (v.rst) begin
      m_owner = -1; m_cnt = 0; m_last = 1; m_pv0 = 0; m_pv1 = 0;
    end else begin
      m_pv0 = 0; m_pv1 = 0;
      if (g0 || g1) begin
        k = g1 ? 1 : 0;
        other = g1 ? v.req0 : v.req1;
        lk = g1 ? v.lk1 : v.lk0;
        if (g1 ? v.we1 : v.we0) begin
          ref_mem[g1 ? v.a1 : v.a0] = g1 ? v.d1 : v.d0;
        end else begin
          m_pdata = ref_mem[g1 ? v.a1 : v.a0];
          if (g1) m_pv1 = 1; else m_pv0 = 1;
        end
        m_cnt = (m_owner == k) ? m_cnt + 1 : 1;
        if (m_cnt > MAXLOCK) m_cnt = MAXLOCK;
        m_last = k;
        if (m_cnt >= MAXLOCK && other) begin
          m_owner = -1; m_cnt = 0;
        end else if (lk) begin
          m_owner = k;
        end else begin
          m_owner = -1; m_cnt = 0;
        end
      end else begin
        m_owner = -1; m_cnt = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t v;
    for (int i = 0; i < (1 << AWID); i++) begin
      mem[i] = '0;
      ref_mem[i] = '0;
    end

    // write then read back through the other requester
    vecs.push_back(mk(1,1,1,0,0,0,0, 8'h00,8'h00, 16'h0,16'h0,     0,0,0,0, 16'h0));
    vecs.push_back(mk(0,1,0,1,0,0,0, 8'h10,8'h00, 16'h1234,16'h0,  1,0,0,0, 16'h0));
    vecs.push_back(mk(0,0,1,0,0,0,0, 8'h00,8'h10, 16'h0,16'h0,     0,1,0,0, 16'h0));
    vecs.push_back(mk(0,0,0,0,0,0,0, 8'h00,8'h00, 16'h0,16'h0,     0,0,0,1, 16'h1234));
    // both requesting without lock: strict alternation
    for (int i = 0; i < 6; i++)
      vecs.push_back(mk(0,1,1,1,1,0,0, 8'h20,8'h21, 16'(i),16'(i+100),
                        (i % 2) == 0, (i % 2) == 1, 0,0, 16'h0));
    // lock limit: MAXLOCK grants to 0, then forced release to 1
    for (int i = 0; i < MAXLOCK; i++)
      vecs.push_back(mk(0,1,1,1,1,1,0, 8'h30,8'h31, 16'(i),16'h0, 1,0,0,0, 16'h0));
    vecs.push_back(mk(0,1,1,1,1,1,0, 8'h30,8'h31, 16'h0,16'h55,   0,1,0,0, 16'h0));
    // lock holder drops its request for one cycle
    vecs.push_back(mk(0,1,0,1,0,1,0, 8'h32,8'h00, 16'h7,16'h0,     1,0,0,0, 16'h0));
    vecs.push_back(mk(0,0,1,0,1,0,0, 8'h00,8'h33, 16'h0,16'h8,     0,0,0,0, 16'h0));
    vecs.push_back(mk(0,0,1,0,1,0,0, 8'h00,8'h33, 16'h0,16'h8,     0,1,0,0, 16'h0));
    // preload then interleaved reads with no bubbles
    vecs.push_back(mk(0,1,0,1,0,0,0, 8'h01,8'h00, 16'hA,16'h0,     1,0,0,0, 16'h0));
    vecs.push_back(mk(0,1,0,1,0,0,0, 8'h02,8'h00, 16'hB,16'h0,     1,0,0,0, 16'h0));
    vecs.push_back(mk(0,1,0,1,0,0,0, 8'h03,8'h00, 16'hC,16'h0,     1,0,0,0, 16'h0));
    vecs.push_back(mk(0,1,0,0,0,0,0, 8'h01,8'h00, 16'h0,16'h0,     1,0,0,0, 16'h0));
    vecs.push_back(mk(0,0,1,0,0,0,0, 8'h00,8'h02, 16'h0,16'h0,     0,1,1,0, 16'hA));
    vecs.push_back(mk(0,1,0,0,0,0,0, 8'h03,8'h00, 16'h0,16'h0,     1,0,0,1, 16'hB));
    vecs.push_back(mk(0,0,0,0,0,0,0, 8'h00,8'h00, 16'h0,16'h0,     0,0,1,0, 16'hC));
    // read immediately followed by reset
    vecs.push_back(mk(0,0,1,0,0,0,1, 8'h00,8'h02, 16'h0,16'h0,     0,1,0,0, 16'h0));
    vecs.push_back(mk(1,1,1,0,0,0,0, 8'h01,8'h02, 16'h0,16'h0,     0,0,0,0, 16'h0));
    vecs.push_back(mk(0,1,1,0,0,0,0, 8'h01,8'h02, 16'h0,16'h0,     1,0,0,0, 16'h0));
    vecs.push_back(mk(0,0,0,0,0,0,0, 8'h00,8'h00, 16'h0,16'h0,     0,0,1,0, 16'hA));

    @(posedge clk);
    #1;
    foreach (vecs[i]) run_cycle(vecs[i], 1'b1);

    for (int n = 0; n < 3000; n++) begin
      v.rst  = ($urandom_range(0, 63) == 0);
      v.req0 = ($urandom_range(0, 9) < 7);
      v.req1 = ($urandom_range(0, 9) < 7);
      v.we0  = $urandom_range(0, 1);
      v.we1  = $urandom_range(0, 1);
      v.lk0  = ($urandom_range(0, 9) < 5);
      v.lk1  = ($urandom_range(0, 9) < 5);
      v.a0   = AWID'($urandom_range(0, 15));
      v.a1   = AWID'($urandom_range(0, 15));
      v.d0   = DWID'($urandom);
      v.d1   = DWID'($urandom);
      v.eg0 = 0; v.eg1 = 0; v.erv0 = 0; v.erv1 = 0; v.erd = '0;
      run_cycle(v, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
